// File: rtl/score_counter.sv
// Frame-paced score keeper feeding the score/letter renderer.
// Distance accrues per frame tick scaled by speed; crashes freeze it, 63 ends the race.
module score_counter #(
    parameter int FRAMES_PER_POINT = 30,
    parameter int CRASH_FRAMES     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       crash,
    input  logic [1:0] speed,
    output logic [5:0] score,
    output logic       score_update,
    output logic       running,
    output logic       crashed,
    output logic       finished
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] FPP_UNITS  = 8'(FRAMES_PER_POINT);
    localparam logic [7:0] PENALTY    = 8'(CRASH_FRAMES);
    localparam logic [5:0] SCORE_MAX  = 6'd63;

    state_t     r_state;
    logic [7:0] r_acc;
    logic [7:0] r_tmr;
    logic [5:0] r_score;
    logic       r_update;
    logic       r_running;
    logic       r_crashed;
    logic       r_finished;

    logic [7:0] w_sum;
    logic       w_point;

    assign w_sum   = r_acc + {6'd0, speed};
    assign w_point = (w_sum >= FPP_UNITS);

    // Status flags are written alongside every state change so they track the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_acc      <= 8'd0;
            r_tmr      <= 8'd0;
            r_score    <= 6'd0;
            r_update   <= 1'b0;
            r_running  <= 1'b0;
            r_crashed  <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (start) begin
                r_state    <= RUN;
                r_acc      <= 8'd0;
                r_tmr      <= 8'd0;
                r_score    <= 6'd0;
                r_running  <= 1'b1;
                r_crashed  <= 1'b0;
                r_finished <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (crash) begin
                            r_state   <= CRASH;
                            r_tmr     <= PENALTY;
                            r_acc     <= 8'd0;
                            r_running <= 1'b0;
                            r_crashed <= 1'b1;
                        end else if (frame_tick) begin
                            if (w_point) begin
                                r_acc    <= w_sum - FPP_UNITS;
                                r_score  <= r_score + 6'd1;
                                r_update <= 1'b1;
                                if (r_score == SCORE_MAX - 6'd1) begin
                                    r_state    <= DONE;
                                    r_running  <= 1'b0;
                                    r_finished <= 1'b1;
                                end
                            end else begin
                                r_acc <= w_sum;
                            end
                        end
                    end
                    CRASH: begin
                        if (frame_tick) begin
                            r_tmr <= r_tmr - 8'd1;
                            if (r_tmr == 8'd1) begin
                                r_state   <= RUN;
                                r_running <= 1'b1;
                                r_crashed <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign score        = r_score;
    assign score_update = r_update;
    assign running      = r_running;
    assign crashed      = r_crashed;
    assign finished     = r_finished;

endmodule

// File: tb/tb_score_counter.sv
// Directed plus randomized bench for score_counter, compared each cycle
// against a distance/penalty model built from plain integer arithmetic.
module tb_score_counter;

    localparam int FPP     = 30;
    localparam int PENALTY = 60;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_CRASH = 2;
    localparam int P_DONE  = 3;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       crash;
    logic [1:0] speed;
    logic [5:0] score;
    logic       score_update;
    logic       running;
    logic       crashed;
    logic       finished;

    int checks   = 0;
    int failures = 0;
    int updCount = 0;

    int mPhase;
    int mScore;
    int mUnits;
    int mPenaltyLeft;
    int mUpdate;

    score_counter #(
        .FRAMES_PER_POINT(FPP),
        .CRASH_FRAMES(PENALTY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .crash(crash),
        .speed(speed),
        .score(score),
        .score_update(score_update),
        .running(running),
        .crashed(crashed),
        .finished(finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mPhase       = P_IDLE;
        mScore       = 0;
        mUnits       = 0;
        mPenaltyLeft = 0;
        mUpdate      = 0;
    endtask

    // Race rules: units banked per tick, one point per FPP units, crash wipes banked units.
    task automatic modelStep(input int st, input int cr, input int tk, input int sp);
        mUpdate = 0;
        if (st != 0) begin
            mPhase       = P_RUN;
            mScore       = 0;
            mUnits       = 0;
            mPenaltyLeft = 0;
        end else if (mPhase == P_RUN && cr != 0) begin
            mPhase       = P_CRASH;
            mPenaltyLeft = PENALTY;
            mUnits       = 0;
        end else if (mPhase == P_RUN && tk != 0) begin
            mUnits = mUnits + sp;
            if (mUnits >= FPP) begin
                mUnits  = mUnits - FPP;
                mScore  = mScore + 1;
                mUpdate = 1;
                if (mScore == 63) mPhase = P_DONE;
            end
        end else if (mPhase == P_CRASH && tk != 0) begin
            mPenaltyLeft = mPenaltyLeft - 1;
            if (mPenaltyLeft == 0) mPhase = P_RUN;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".score"},    32'(score),        32'(mScore));
        checkValue({tag, ".update"},   32'(score_update), 32'(mUpdate));
        checkValue({tag, ".running"},  32'(running),      32'(mPhase == P_RUN));
        checkValue({tag, ".crashed"},  32'(crashed),      32'(mPhase == P_CRASH));
        checkValue({tag, ".finished"}, 32'(finished),     32'(mPhase == P_DONE));
    endtask

    // One clock: drive on the falling edge, model the rising edge, check just after it.
    task automatic applyStimulus(input string tag, input int st, input int cr, input int tk, input int sp);
        @(negedge clk);
        start      = (st != 0);
        crash      = (cr != 0);
        frame_tick = (tk != 0);
        speed      = 2'(sp);
        @(posedge clk);
        modelStep(st, cr, tk, sp);
        #1;
        if (score_update === 1'b1) updCount++;
        checkOutput(tag);
    endtask

    task automatic ticks(input string tag, input int n, input int sp);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 0, 0, 1, sp);
            applyStimulus(tag, 0, 0, 0, sp);
        end
    endtask

    initial begin
        int lastTick;
        int guard;
        reset      = 1'b0;
        start      = 1'b0;
        crash      = 1'b0;
        frame_tick = 1'b0;
        speed      = 2'd0;
        modelReset();
        #12;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("tick_in_idle", 0, 0, 1, 3);
        applyStimulus("crash_in_idle", 0, 1, 0, 3);

        $display("[TB] basic count");
        applyStimulus("start", 1, 0, 0, 3);
        updCount = 0;
        ticks("basic", 10, 3);
        checkValue("basic.score10", 32'(score), 32'd1);
        checkValue("basic.pulses10", 32'(updCount), 32'd1);
        ticks("basic", 20, 3);
        checkValue("basic.score30", 32'(score), 32'd3);

        $display("[TB] remainder carry");
        applyStimulus("restart", 1, 0, 0, 0);
        ticks("carry", 29, 1);
        ticks("carry", 1, 3);
        checkValue("carry.score", 32'(score), 32'd1);
        ticks("carry", 27, 1);
        checkValue("carry.acc2_hold", 32'(score), 32'd1);
        ticks("carry", 1, 1);
        checkValue("carry.acc2_point", 32'(score), 32'd2);

        $display("[TB] stopped car");
        updCount = 0;
        ticks("stopped", 100, 0);
        checkValue("stopped.score", 32'(score), 32'd2);
        checkValue("stopped.pulses", 32'(updCount), 32'd0);
        ticks("stopped_after", 9, 3);
        ticks("stopped_after", 1, 3);
        checkValue("stopped.acc_kept", 32'(score), 32'd3);

        $display("[TB] crash penalty");
        applyStimulus("restart", 1, 0, 0, 0);
        ticks("pre_crash", 50, 3);
        checkValue("pre_crash.score", 32'(score), 32'd5);
        ticks("pre_crash", 1, 3);
        applyStimulus("crash", 0, 1, 0, 3);
        checkValue("crash.crashed", 32'(crashed), 32'd1);
        checkValue("crash.running", 32'(running), 32'd0);
        ticks("penalty", 30, 3);
        applyStimulus("second_crash", 0, 1, 0, 3);
        ticks("penalty", 29, 3);
        checkValue("penalty.still_crashed", 32'(crashed), 32'd1);
        checkValue("penalty.score", 32'(score), 32'd5);
        ticks("penalty_end", 1, 3);
        checkValue("penalty_end.running", 32'(running), 32'd1);
        ticks("post_crash", 9, 3);
        checkValue("post_crash.acc_cleared", 32'(score), 32'd5);
        ticks("post_crash", 1, 3);
        checkValue("post_crash.point", 32'(score), 32'd6);

        $display("[TB] saturation");
        guard = 0;
        while (finished !== 1'b1 && guard < 2000) begin
            ticks("saturate", 1, 3);
            guard++;
        end
        checkValue("saturate.reached", 32'(guard < 2000), 32'd1);
        checkValue("saturate.score", 32'(score), 32'd63);
        ticks("done_hold", 5, 3);
        applyStimulus("done_crash", 0, 1, 1, 3);
        checkValue("done_hold.score", 32'(score), 32'd63);
        applyStimulus("done_start", 1, 0, 0, 3);
        checkValue("done_start.score", 32'(score), 32'd0);
        checkValue("done_start.running", 32'(running), 32'd1);
        checkValue("done_start.finished", 32'(finished), 32'd0);

        $display("[TB] collisions");
        ticks("collide_pre", 9, 3);
        applyStimulus("crash_and_tick", 0, 1, 1, 3);
        checkValue("crash_and_tick.score", 32'(score), 32'd0);
        checkValue("crash_and_tick.crashed", 32'(crashed), 32'd1);
        applyStimulus("start_and_crash", 1, 1, 0, 3);
        checkValue("start_and_crash.running", 32'(running), 32'd1);
        ticks("to_twelve", 120, 3);
        checkValue("to_twelve.score", 32'(score), 32'd12);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("post_reset_tick", 0, 0, 1, 3);

        $display("[TB] randomized run");
        applyStimulus("rand_start", 1, 0, 0, 0);
        lastTick = 0;
        for (int i = 0; i < 4000; i++) begin
            int st;
            int cr;
            int tk;
            int sp;
            st = ($urandom_range(0, 199) == 0) ? 1 : 0;
            cr = ($urandom_range(0, 59) == 0) ? 1 : 0;
            tk = (lastTick == 0 && $urandom_range(0, 9) < 6) ? 1 : 0;
            sp = int'($urandom_range(0, 3));
            lastTick = tk;
            applyStimulus("random", st, cr, tk, sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
